// File: rtl/fifo_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rx_param
// Brief    : Parametrised single-clock receive FIFO with thresholds, show-ahead
//            read mode and overflow/underflow pulses.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rx_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2,
    parameter int SHOWAHEAD = 0
) (
    input  logic              clock,
    input  logic              aclr_n,
    input  logic              sclr,
    input  logic [DATA_W-1:0] data,
    input  logic              wrreq,
    input  logic              rdreq,
    output logic [DATA_W-1:0] q,
    output logic [ADDR_W:0]   usedw,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int               c_depth     = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  c_depth_cnt = (ADDR_W+1)'(c_depth);
    localparam logic [ADDR_W:0]  c_af        = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0]  c_ae        = (ADDR_W+1)'(AE_THRESH);

    logic [DATA_W-1:0] r_mem [c_depth];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_usedw;
    logic              r_empty;
    logic              r_full;
    logic              r_af;
    logic              r_ae;
    logic              r_ovf;
    logic              r_unf;

    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [ADDR_W:0]   w_usedw_nxt;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a write.
    assign w_rd_acc = rdreq && !r_empty;
    assign w_wr_acc = wrreq && (!r_full || w_rd_acc);

    always_comb begin
        w_usedw_nxt = r_usedw;
        if (w_wr_acc && !w_rd_acc) begin
            w_usedw_nxt = r_usedw + (ADDR_W+1)'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_usedw_nxt = r_usedw - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (sclr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_usedw <= w_usedw_nxt;
            r_empty <= (w_usedw_nxt == '0);
            r_full  <= (w_usedw_nxt == c_depth_cnt);
            r_af    <= (w_usedw_nxt >= c_af);
            r_ae    <= (w_usedw_nxt < c_ae);
            r_ovf   <= wrreq && r_full && !rdreq;
            r_unf   <= rdreq && r_empty;
        end
    end

    // Storage has no reset so it maps onto a plain dual-port RAM.
    always_ff @(posedge clock) begin
        if (w_wr_acc && !sclr) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            assign q = r_mem[r_rd_ptr];
        end else begin : g_normal
            logic [DATA_W-1:0] r_q;
            always_ff @(posedge clock or negedge aclr_n) begin
                if (!aclr_n) begin
                    r_q <= '0;
                end else if (sclr) begin
                    r_q <= '0;
                end else if (w_rd_acc) begin
                    r_q <= r_mem[r_rd_ptr];
                end
            end
            assign q = r_q;
        end
    endgenerate

    assign usedw        = r_usedw;
    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rx_param
// Brief    : Self-checking bench for fifo_rx_param: queue model plus directed
//            vectors, default build and a 12x8 show-ahead build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rx_param;

    logic        clock;
    logic        aclr_n;
    logic        sclr;
    logic [7:0]  data;
    logic        wrreq;
    logic        rdreq;
    logic [7:0]  q;
    logic [4:0]  usedw;
    logic        empty, full, almost_full, almost_empty, overflow, underflow;

    logic        sa_wr, sa_rd;
    logic [11:0] sa_d;
    logic [11:0] sa_q;
    logic [3:0]  sa_usedw;
    logic        sa_empty, sa_full, sa_af, sa_ae, sa_ovf, sa_unf;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    fifo_rx_param u_dut (
        .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .data(data),
        .wrreq(wrreq), .rdreq(rdreq), .q(q), .usedw(usedw),
        .empty(empty), .full(full), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
    );

    fifo_rx_param #(
        .DATA_W(12), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(2), .SHOWAHEAD(1)
    ) u_sa (
        .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .data(sa_d),
        .wrreq(sa_wr), .rdreq(sa_rd), .q(sa_q), .usedw(sa_usedw),
        .empty(sa_empty), .full(sa_full), .almost_full(sa_af),
        .almost_empty(sa_ae), .overflow(sa_ovf), .underflow(sa_unf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model of the default build: a word queue and the declared flag rules.
    logic [7:0] mq[$];
    logic [7:0] m_q   = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    always @(posedge clock or negedge aclr_n) begin
        bit is_full, is_empty, rd_ok, wr_ok;
        if (!aclr_n || sclr) begin
            mq.delete();
            m_q   = 8'h00;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            is_full  = (mq.size() == 16);
            is_empty = (mq.size() == 0);
            rd_ok    = rdreq && !is_empty;
            wr_ok    = wrreq && (!is_full || rd_ok);
            m_ovf    = wrreq && is_full && !rdreq;
            m_unf    = rdreq && is_empty;
            if (rd_ok) m_q = mq.pop_front();
            if (wr_ok) mq.push_back(data);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            cmp("model_usedw", 32'(usedw), 32'(mq.size()));
            cmp("model_flags", {28'd0, empty, full, almost_full, almost_empty},
                {28'd0, mq.size() == 0, mq.size() == 16, mq.size() >= 12, mq.size() < 2});
            cmp("model_q", 32'(q), 32'(m_q));
            cmp("model_pulses", {30'd0, overflow, underflow}, {30'd0, m_ovf, m_unf});
        end
    end

    // Drive one cycle of requests at a falling edge; returns at the next one.
    task automatic drive(input logic w, input logic r, input logic [7:0] d, input logic s);
        wrreq = w;
        rdreq = r;
        data  = d;
        sclr  = s;
        @(negedge clock);
        wrreq = 1'b0;
        rdreq = 1'b0;
        sclr  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq [4];
        int ovf_seen;
        seq[0] = 8'h56; seq[1] = 8'hAA; seq[2] = 8'hFF; seq[3] = 8'hAA;
        aclr_n = 1'b0; sclr = 1'b0; data = '0; wrreq = 1'b0; rdreq = 1'b0;
        sa_wr = 1'b0; sa_rd = 1'b0; sa_d = '0;
        repeat (2) @(negedge clock);
        aclr_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clock);
        cmp("reset_usedw", 32'(usedw), 0);
        cmp("reset_flags", {28'd0, empty, almost_empty, full, almost_full}, 32'b1100);
        cmp("reset_q", 32'(q), 0);

        // Ordered transfer
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, seq[i], 1'b0);
            cmp("wr_usedw", 32'(usedw), 32'(i + 1));
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'h00, 1'b0);
            cmp("rd_q", 32'(q), 32'(seq[i]));
            cmp("rd_usedw", 32'(usedw), 32'(3 - i));
        end
        cmp("rd_empty", 32'(empty), 1);

        // Thresholds, full and overflow
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(i), 1'b0);
            cmp("thr_ae", 32'(almost_empty), 32'(i + 1 < 2));
            cmp("thr_af", 32'(almost_full), 32'(i + 1 >= 12));
            cmp("thr_full", 32'(full), 32'(i + 1 == 16));
        end
        ovf_seen = 0;
        drive(1'b1, 1'b0, 8'hEE, 1'b0);
        if (overflow) ovf_seen++;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        if (overflow) ovf_seen++;
        cmp("ovf_pulses", 32'(ovf_seen), 1);
        cmp("ovf_usedw", 32'(usedw), 16);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'h00, 1'b0);
            cmp("ovf_readback", 32'(q), 32'(i));
        end

        // Underflow and simultaneous access
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        cmp("unf_pulse", 32'(underflow), 1);
        cmp("unf_q_hold", 32'(q), 32'h0F);
        drive(1'b1, 1'b1, 8'h77, 1'b0);
        cmp("empty_wr_rd_usedw", 32'(usedw), 1);
        cmp("empty_wr_rd_unf", 32'(underflow), 1);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        cmp("empty_wr_rd_q", 32'(q), 32'h77);
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
            cmp("wrap_q", 32'(q), (i < 16) ? 32'(8'h20 + i) : 32'(8'h40 + i - 16));
            cmp("wrap_usedw", 32'(usedw), 16);
            cmp("wrap_ovf", 32'(overflow), 0);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'h00, 1'b0);
            cmp("wrap_drain", 32'(q), 32'(8'h44 + i));
        end

        // Synchronous clear with concurrent write
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
        drive(1'b1, 1'b0, 8'h99, 1'b1);
        cmp("sclr_usedw", 32'(usedw), 0);
        cmp("sclr_empty", 32'(empty), 1);
        cmp("sclr_q", 32'(q), 0);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        cmp("sclr_discard", 32'(underflow), 1);

        // Asynchronous clear between edges
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        cmp("pre_aclr_q", 32'(q), 32'h60);
        #2 aclr_n = 1'b0;
        #1;
        cmp("aclr_usedw", 32'(usedw), 0);
        cmp("aclr_empty", 32'(empty), 1);
        cmp("aclr_q", 32'(q), 0);
        @(negedge clock);
        aclr_n = 1'b1;

        // Show-ahead build
        sa_wr = 1'b1; sa_d = 12'hABC;
        @(negedge clock);
        sa_wr = 1'b0;
        cmp("sa_first_word", 32'(sa_q), 32'hABC);
        cmp("sa_not_empty", 32'(sa_empty), 0);
        @(negedge clock);
        cmp("sa_hold", 32'(sa_q), 32'hABC);
        sa_wr = 1'b1; sa_d = 12'h123; sa_rd = 1'b1;
        @(negedge clock);
        sa_wr = 1'b0; sa_rd = 1'b0;
        cmp("sa_advance", 32'(sa_q), 32'h123);
        cmp("sa_usedw", 32'(sa_usedw), 1);
        sa_rd = 1'b1;
        @(negedge clock);
        sa_rd = 1'b0;
        cmp("sa_empty_after", 32'(sa_empty), 1);

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
